// File: rtl/encoder4x2_queue.sv
// 4-to-2 priority encoder with a pending-request register and a valid/ready output stage.
// Requests are captured into pend, then served highest-priority first, one code per handshake.
//
// state | meaning
// IDLE  | no code presented, valid=0
// HOLD  | code on {a,b} presented, valid=1, waiting for ready
module encoder4x2_queue (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       ovf,
  output logic [3:0] pend
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] req;
  logic [3:0] served;
  logic [3:0] pend_d;
  logic [1:0] sel_code;
  logic [1:0] code_q;
  logic       load;
  logic       ovf_set;

  always_comb begin
    req = {d4, d3, d2, d1} & {4{en}};
  end

  // Selection looks only at the registered pend, so same-edge captures wait a cycle.
  always_comb begin
    sel_code = 2'd0;
    if (pend[3])      sel_code = 2'd3;
    else if (pend[2]) sel_code = 2'd2;
    else if (pend[1]) sel_code = 2'd1;
    else              sel_code = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend != 4'b0000) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (pend != 4'b0000) begin
            load    = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A set on the same edge as the clear wins, which also re-queues the held code.
  always_comb begin
    served  = load ? (4'b0001 << sel_code) : 4'b0000;
    pend_d  = (pend & ~served) | req;
    ovf_set = |(req & pend & ~served);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend    <= 4'b0000;
      code_q  <= 2'b00;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend    <= pend_d;
      if (load) code_q <= sel_code;
      if (ovf_set) ovf <= 1'b1;
    end
  end

  assign a     = code_q[1];
  assign b     = code_q[0];
  assign valid = (state_q == HOLD);

endmodule

// File: tb/tb_encoder4x2_queue.sv
// Directed bench for encoder4x2_queue: expected codes go into a scoreboard queue,
// a monitor pops them on every valid&ready handshake; state checks run inline.
module tb_encoder4x2_queue;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d1, d2, d3, d4;
  logic       ready;
  logic       a, b, valid, ovf;
  logic [3:0] pend;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  bit done = 0;

  encoder4x2_queue dut (
    .clk(clk), .rst(rst), .en(en),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .ready(ready), .a(a), .b(b), .valid(valid), .ovf(ovf), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic e, input logic [3:0] d);
    en = e;
    {d4, d3, d2, d1} = d;
  endtask

  // Monitor: every handshake must match the next expected code.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (!rst && valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_code: got %b%b with no code expected at %0t", a, b, $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if ({a, b} !== e) begin
            errors++;
            $display("FAIL code: got %b%b expected %b at %0t", a, b, e, $time);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ready = 1'b1;
    req(1'b0, 4'b0000);
    #3;
    chk("reset_pend", pend, 4'b0000);
    chk("reset_valid_ovf_ab", {valid, ovf, a, b}, 4'b0000);
    step();
    rst = 1'b0;

    // single request d3
    exp_q.push_back(2'b10);
    req(1'b1, 4'b0100);
    step();
    chk("t1_pend_capture", pend, 4'b0100);
    chk("t1_valid_lat", {3'b0, valid}, 4'b0000);
    req(1'b0, 4'b0000);
    step();
    chk("t1_out", {1'b0, valid, a, b}, 4'b0110);
    step();
    chk("t1_idle", {valid, 3'b0}, 4'b0000);
    chk("t1_pend_empty", pend, 4'b0000);

    // priority burst
    exp_q.push_back(2'b11); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b00);
    req(1'b1, 4'b1111);
    step();
    chk("t2_pend_all", pend, 4'b1111);
    req(1'b0, 4'b0000);
    step(); chk("t2_c0", {1'b0, valid, a, b}, 4'b0111);
    chk("t2_pend_after_first", pend, 4'b0111);
    step(); chk("t2_c1", {1'b0, valid, a, b}, 4'b0110);
    step(); chk("t2_c2", {1'b0, valid, a, b}, 4'b0101);
    step(); chk("t2_c3", {1'b0, valid, a, b}, 4'b0100);
    step(); chk("t2_done", {3'b0, valid}, 4'b0000);

    // backpressure
    ready = 1'b0;
    req(1'b1, 4'b0010);
    step();
    req(1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_hold%0d", i), {1'b0, valid, a, b}, 4'b0101);
    end
    exp_q.push_back(2'b01);
    ready = 1'b1;
    step();
    chk("t3_release", {3'b0, valid}, 4'b0000);

    // gating and overflow
    req(1'b0, 4'b1000);
    step();
    chk("t4_gated", pend, 4'b0000);
    chk("t4_gated_valid", {3'b0, valid}, 4'b0000);
    ready = 1'b0;
    req(1'b1, 4'b1000);
    step();
    req(1'b0, 4'b0000);
    step();
    chk("t4_held11", {1'b0, valid, a, b}, 4'b0111);
    req(1'b1, 4'b0001);
    step();
    chk("t4_first_d1", {ovf, 3'b0}, 4'b0000);
    chk("t4_pend1", pend, 4'b0001);
    req(1'b0, 4'b0000);
    step();
    req(1'b1, 4'b0001);
    step();
    chk("t4_ovf", {ovf, 3'b0}, 4'b1000);
    chk("t4_pend2", pend, 4'b0001);
    req(1'b0, 4'b0000);
    exp_q.push_back(2'b11); exp_q.push_back(2'b00);
    ready = 1'b1;
    step();
    chk("t4_b2b", {1'b0, valid, a, b}, 4'b0100);
    step();
    chk("t4_drain", {ovf, 2'b0, valid}, 4'b1000);

    // reset mid-operation with pend=1010 and a code held
    ready = 1'b0;
    req(1'b1, 4'b0100);
    step();
    req(1'b0, 4'b0000);
    step();
    req(1'b1, 4'b1010);
    step();
    req(1'b0, 4'b0000);
    chk("t5_pre_pend", pend, 4'b1010);
    chk("t5_pre_valid", {1'b0, valid, a, b}, 4'b0110);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_pend", pend, 4'b0000);
    chk("t5_async_flags", {valid, ovf, a, b}, 4'b0000);
    req(1'b1, 4'b1111);
    step();
    chk("t5_ignored_in_rst", pend, 4'b0000);
    req(1'b0, 4'b0000);
    ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_quiet%0d", i), {pend[2:0], valid}, 4'b0000);
    end
    exp_q.push_back(2'b01);
    req(1'b1, 4'b0010);
    step();
    chk("t5_recapture", pend, 4'b0010);
    req(1'b0, 4'b0000);
    step();
    chk("t5_out", {1'b0, valid, a, b}, 4'b0101);
    step();
    chk("t5_idle", {3'b0, valid}, 4'b0000);

    step();
    chk("scoreboard_empty", exp_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);
    done = 1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: run did not complete at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
